// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - shared types and defaults for the ram_master access initiator
package ram_master_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 32;

  // A length field of zero stands for a full sweep of the address space.
  localparam bit LEN_ZERO_IS_MAX = 1'b1;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/ram_master_addr_gen.sv
// rtl/ram_master_addr_gen.sv - wrapping address counter and remaining-word counter
module ram_master_addr_gen
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  // One extra bit so a full-depth burst is representable.
  logic [ADDR_W:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
      if (LEN_ZERO_IS_MAX && (load_len == '0))
        remaining <= {1'b1, {ADDR_W{1'b0}}};
      else
        remaining <= {1'b0, load_len};
    end else if (step) begin
      cur_addr  <= cur_addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/ram_master.sv
// rtl/ram_master.sv - burst command sequencer; sole driver of the single-port RAM pins
// Fill command is built only when RAM_MASTER_FILL_EN is defined.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state;
  logic [ADDR_W-1:0] cur_addr;
  logic              last;
  logic              start;
  logic              access;
  logic              rd_en;

`ifdef RAM_MASTER_FILL_EN
  logic [DATA_W-1:0] fill_data;
`else
  logic              unused_cmd_data;
  assign unused_cmd_data = ^cmd_data;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WR);
  assign rd_en     = !rd_valid || rd_ready;

  // Only real burst commands load the counters; rejected ops leave them untouched.
  always_comb begin
    start = 1'b0;
    if (cmd_valid && (state == S_IDLE)) begin
      case (op_e'(cmd_op))
        OP_READ, OP_WRITE: start = 1'b1;
`ifdef RAM_MASTER_FILL_EN
        OP_FILL:           start = 1'b1;
`endif
        default:           start = 1'b0;
      endcase
    end
  end

  always_comb begin
    access    = 1'b0;
    ram_wena  = 1'b0;
    ram_wdata = '0;
    case (state)
      S_RD: access = rd_en;
      S_WR: begin
        access    = wr_valid;
        ram_wena  = wr_valid;
        ram_wdata = wr_data;
      end
`ifdef RAM_MASTER_FILL_EN
      S_FILL: begin
        access    = 1'b1;
        ram_wena  = 1'b1;
        ram_wdata = fill_data;
      end
`endif
      default: access = 1'b0;
    endcase
  end

  assign ram_ena  = access;
  assign ram_addr = ((state == S_IDLE) || (state == S_DONE)) ? '0 : cur_addr;

  ram_master_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (start),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .step      (access),
    .cur_addr  (cur_addr),
    .last      (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef RAM_MASTER_FILL_EN
      fill_data <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // A new read beat may replace a beat being consumed on the same edge.
      if ((state == S_RD) && rd_en) begin
        rd_valid <= 1'b1;
        rd_data  <= ram_rdata;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (op_e'(cmd_op))
              OP_READ:  state <= S_RD;
              OP_WRITE: state <= S_WR;
`ifdef RAM_MASTER_FILL_EN
              OP_FILL: begin
                state     <= S_FILL;
                fill_data <= cmd_data;
              end
`endif
              default:  err <= 1'b1;
            endcase
          end
        end
        S_RD, S_WR, S_FILL: begin
          if (access && last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master with a behavioural 32x32 RAM
module tb_ram_master;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_FL = 2'b10, OP_RS = 2'b11;
  localparam logic [1:0] EV_DONE = 2'b01, EV_ERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic [DW-1:0] cmd_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic          ram_ena, ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM: synchronous write, combinational read, floating when not reading.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = (ram_ena && !ram_wena) ? mem[ram_addr] : 'z;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] rd_q [$];
  logic [1:0]    ev_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) chk("rd_extra_beat", 64'(rd_data), 64'hFFFF_FFFF_0000_0000);
        else chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
      end
      if (done || err) begin
        if (ev_q.size() == 0) chk("event_unexpected", 64'({err, done}), 64'd0);
        else chk("event", 64'({err, done}), 64'(ev_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nwords(input logic [AW-1:0] l);
    return (l == '0) ? DEPTH : int'(l);
  endfunction

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] l,
                       input logic [DW-1:0] d);
    int t = 0;
    while (!cmd_ready && t < 100) begin
      tick();
      t++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                          input logic [DW-1:0] base, input bit rnd, input bit gaps);
    int n = nwords(l);
    logic [DW-1:0] d;
    ev_q.push_back(EV_DONE);
    issue(OP_WR, a, l, $urandom);
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(3) == 0) begin
        wr_valid = 1'b0;
        tick();
      end
      chk("wr_ready", 64'(wr_ready), 64'd1);
      d = rnd ? DW'($urandom) : base + DW'(i);
      wr_valid = 1'b1;
      wr_data  = d;
      ref_mem[(int'(a) + i) % DEPTH] = d;
      tick();
    end
    wr_valid = 1'b0;
    chk("wr_done_after_last_beat", 64'(done), 64'd1);
    tick();
  endtask

  // mode 0: always ready, 1: random back-pressure, 2: 3-cycle stall at start
  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode);
    int n  = nwords(l);
    int t  = 0;
    int d0 = done_cnt;
    for (int i = 0; i < n; i++) rd_q.push_back(ref_mem[(int'(a) + i) % DEPTH]);
    ev_q.push_back(EV_DONE);
    rd_ready = (mode == 0);
    issue(OP_RD, a, l, $urandom);
    if (mode == 2) begin
      chk("rd_first_access", 64'(ram_ena), 64'd1);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("rd_stall_ena_low", 64'(ram_ena), 64'd0);
      end
      rd_ready = 1'b1;
    end
    while (done_cnt == d0 && t < 400) begin
      if (mode == 1) rd_ready = 1'($urandom_range(1));
      tick();
      t++;
    end
    chk("rd_done_seen", 64'(done_cnt != d0), 64'd1);
    rd_ready = 1'b1;
    tick();
    tick();
    chk("rd_drained", 64'(rd_valid), 64'd0);
  endtask

  task automatic do_reject(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] l);
    ev_q.push_back(EV_ERR);
    issue(op, a, l, $urandom);
    chk("rej_err_pulse", 64'(err), 64'd1);
    chk("rej_no_access", 64'(ram_ena), 64'd0);
    tick();
    chk("rej_no_access_2", 64'(ram_ena), 64'd0);
    chk("rej_idle", 64'(cmd_ready), 64'd1);
    chk("rej_err_one_cycle", 64'(err), 64'd0);
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [DW-1:0] d);
`ifdef RAM_MASTER_FILL_EN
    int n = nwords(l);
    ev_q.push_back(EV_DONE);
    for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % DEPTH] = d;
    issue(OP_FL, a, l, d);
    chk("fill_ena",   64'({ram_ena, ram_wena}), 64'd3);
    chk("fill_addr",  64'(ram_addr), 64'(a));
    chk("fill_wdata", 64'(ram_wdata), 64'(d));
    for (int i = 0; i < n - 1; i++) tick();
    chk("fill_done_not_early", 64'(done), 64'd0);
    tick();
    chk("fill_done", 64'(done), 64'd1);
    tick();
`else
    do_reject(OP_FL, a, l);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a, l;
    int d0, r;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_data = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rd_valid",  64'(rd_valid), 64'd0);
    chk("rst_rd_data",   64'(rd_data), 64'd0);
    chk("rst_done_err",  64'({done, err}), 64'd0);
    chk("rst_ram_ctl",   64'({ram_ena, ram_wena}), 64'd0);
    chk("rst_ram_addr",  64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_wr_ready",  64'(wr_ready), 64'd0);
    rst = 1'b0;
    tick();

    // wrapping write, stalled read-back, full-depth write
    do_write(5'd30, 5'd4, 32'hA0A0_0000, 1'b0, 1'b0);
    chk("t1_mem30", 64'(mem[30]), 64'hA0A0_0000);
    chk("t1_mem1",  64'(mem[1]),  64'hA0A0_0003);
    do_read(5'd30, 5'd4, 2);
    d0 = done_cnt;
    do_write(5'd7, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("t3_one_done", 64'(done_cnt - d0), 64'd1);
    do_read(5'd0, 5'd0, 0);

    // reset in the middle of a 5-beat write
    d0 = done_cnt;
    issue(OP_WR, 5'd10, 5'd5, 32'h0);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hB0B0_0000 + DW'(i);
      ref_mem[10 + i] = wr_data;
      tick();
    end
    wr_data = 32'hBAD0_BAD0;
    #2 rst = 1'b1;
    #1;
    chk("t4_ena_drop",  64'(ram_ena), 64'd0);
    chk("t4_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_mem10", 64'(mem[10]), 64'hB0B0_0000);
    chk("t4_mem11", 64'(mem[11]), 64'hB0B0_0001);
    chk("t4_mem12", 64'(mem[12]), 64'(ref_mem[12]));

    do_fill(5'd4, 5'd3, 32'hDEAD_BEEF);
    do_reject(OP_RS, 5'd3, 5'd2);
    do_read(5'd3, 5'd6, 0);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(9);
      a = AW'($urandom);
      l = ($urandom_range(5) == 0) ? 5'd0 : AW'($urandom_range(8, 1));
      if (r < 4)       do_write(a, l, 32'h0, 1'b1, 1'b1);
      else if (r < 8)  do_read(a, l, 1);
      else if (r == 8) do_fill(a, l, DW'($urandom));
      else             do_reject(OP_RS, a, l);
    end

    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("ev_q_empty", 64'(ev_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
